// File: rtl/cart_mapper.sv
// 2600 cartridge bank-switch stage: snoops the 6502 bus, tracks the bank registers
// for the 4K/F8/F6/F4/E0/3F schemes, forms the linear ROM address and hosts SuperChip RAM.
module cart_mapper #(
  parameter int ROM_ADDR_BITS = 15,
  parameter int SC_DEPTH      = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [12:0]              adr_i,
  input  logic                     we_i,
  input  logic [7:0]               dat_i,
  input  logic [2:0]               mapper_i,
  input  logic                     superchip_i,
  output logic [ROM_ADDR_BITS-1:0] rom_addr_o,
  input  logic [7:0]               rom_dat_i,
  output logic [7:0]               dat_o,
  output logic [15:0]              diag_o
);

  localparam int SC_AW = $clog2(SC_DEPTH);

  localparam logic [2:0] MAP_NONE = 3'd0;
  localparam logic [2:0] MAP_F8   = 3'd1;
  localparam logic [2:0] MAP_F6   = 3'd2;
  localparam logic [2:0] MAP_F4   = 3'd3;
  localparam logic [2:0] MAP_E0   = 3'd4;
  localparam logic [2:0] MAP_3F   = 3'd5;

  logic [2:0]  mode;
  logic [2:0]  mapper_q;
  logic        reload;

  logic        bank_f8;
  logic [1:0]  bank_f6;
  logic [2:0]  bank_f4;
  logic [2:0]  bank_e0_0;
  logic [2:0]  bank_e0_1;
  logic [2:0]  bank_e0_2;
  logic [3:0]  bank_3f;

  logic        hot;
  logic        f8_hit;
  logic        f6_hit;
  logic        f4_hit;
  logic        e0_hit;
  logic        tf_hit;
  logic [1:0]  f6_sel;
  logic [2:0]  f4_sel;

  logic [14:0] lin_addr;
  logic [7:0]  bank_cur;
  logic [2:0]  e0_cur;
  logic [3:0]  tf_cur;

  logic        sc_en;
  logic        sc_wr;
  logic        sc_rd;
  logic [7:0]  sc_ram [SC_DEPTH];
  logic [7:0]  sc_dat_p1;
  logic        sc_vld_p1;

  // Unused encodings 6/7 behave as a plain 4K cartridge.
  always_comb begin
    mode = mapper_i;
    if (mapper_i > MAP_3F) mode = MAP_NONE;
  end

  always_ff @(posedge clk_i) begin
    mapper_q <= mode;
  end

  assign reload = rst_i || (mode != mapper_q);

  assign hot    = adr_i[12];
  assign f8_hit = hot && (adr_i[11:1] == 11'h7FC);
  assign f6_hit = hot && (adr_i[11:4] == 8'hFF) && (adr_i[3:0] >= 4'h6) && (adr_i[3:0] <= 4'h9);
  assign f4_hit = hot && (adr_i[11:4] == 8'hFF) && (adr_i[3:0] >= 4'h4) && (adr_i[3:0] <= 4'hB);
  assign e0_hit = hot && (adr_i[11:5] == 7'h7F) && (adr_i[4:3] != 2'b11);
  assign tf_hit = we_i && (adr_i[12:6] == 7'd0);

  // Hotspot offsets from the window base, folded into modular adds: xFF6->0, xFF4->0.
  assign f6_sel = adr_i[1:0] + 2'd2;
  assign f4_sel = adr_i[2:0] + 3'd4;

  // A mapper change or reset reloads the power-on banks and outranks any hotspot.
  always_ff @(posedge clk_i) begin
    if (reload) begin
      bank_f8   <= 1'b1;
      bank_f6   <= 2'd3;
      bank_f4   <= 3'd7;
      bank_e0_0 <= 3'd0;
      bank_e0_1 <= 3'd1;
      bank_e0_2 <= 3'd2;
      bank_3f   <= 4'd0;
    end else if (enable_i) begin
      case (mode)
        MAP_F8: if (f8_hit) bank_f8 <= adr_i[0];
        MAP_F6: if (f6_hit) bank_f6 <= f6_sel;
        MAP_F4: if (f4_hit) bank_f4 <= f4_sel;
        MAP_E0: begin
          if (e0_hit) begin
            case (adr_i[4:3])
              2'd0:    bank_e0_0 <= adr_i[2:0];
              2'd1:    bank_e0_1 <= adr_i[2:0];
              default: bank_e0_2 <= adr_i[2:0];
            endcase
          end
        end
        MAP_3F: if (tf_hit) bank_3f <= dat_i[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    case (adr_i[11:10])
      2'd0:    e0_cur = bank_e0_0;
      2'd1:    e0_cur = bank_e0_1;
      2'd2:    e0_cur = bank_e0_2;
      default: e0_cur = 3'd7;
    endcase
  end

  assign tf_cur = adr_i[11] ? 4'hF : bank_3f;

  always_comb begin
    lin_addr = {3'b000, adr_i[11:0]};
    bank_cur = 8'd0;
    case (mode)
      MAP_F8: begin
        lin_addr = {2'b00, bank_f8, adr_i[11:0]};
        bank_cur = {7'd0, bank_f8};
      end
      MAP_F6: begin
        lin_addr = {1'b0, bank_f6, adr_i[11:0]};
        bank_cur = {6'd0, bank_f6};
      end
      MAP_F4: begin
        lin_addr = {bank_f4, adr_i[11:0]};
        bank_cur = {5'd0, bank_f4};
      end
      MAP_E0: begin
        lin_addr = {2'b00, e0_cur, adr_i[9:0]};
        bank_cur = {5'd0, e0_cur};
      end
      MAP_3F: begin
        lin_addr = {tf_cur, adr_i[10:0]};
        bank_cur = {4'd0, tf_cur};
      end
      default: ;
    endcase
  end

  assign rom_addr_o = ROM_ADDR_BITS'(lin_addr);
  assign diag_o     = {mapper_i, superchip_i, 4'b0000, bank_cur};

  // SuperChip: write window x1000-x107F, read window x1080-x10FF.
  assign sc_en = superchip_i && ((mode == MAP_F8) || (mode == MAP_F6) || (mode == MAP_F4));
  assign sc_wr = sc_en && enable_i && we_i && (adr_i[12:7] == 6'b100000);
  assign sc_rd = sc_en && (adr_i[12:7] == 6'b100001);

  // ---- p0 -> p1: RAM read registered to line up with the dprom latency ----
  always_ff @(posedge clk_i) begin
    if (sc_wr) sc_ram[adr_i[SC_AW-1:0]] <= dat_i;
    sc_dat_p1 <= sc_ram[adr_i[SC_AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sc_vld_p1 <= 1'b0;
    else       sc_vld_p1 <= sc_rd;
  end

  assign dat_o = sc_vld_p1 ? sc_dat_p1 : rom_dat_i;

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper: each task drives one scheme and checks hand-computed addresses/data.
module tb_cart_mapper;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [12:0] adr;
  logic        we;
  logic [7:0]  dat;
  logic [2:0]  mapper;
  logic        superchip;
  logic [14:0] rom_addr;
  logic [7:0]  rom_dat;
  logic [7:0]  dat_out;
  logic [15:0] diag;

  int checks = 0;
  int errors = 0;

  cart_mapper #(.ROM_ADDR_BITS(15), .SC_DEPTH(128)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .adr_i       (adr),
    .we_i        (we),
    .dat_i       (dat),
    .mapper_i    (mapper),
    .superchip_i (superchip),
    .rom_addr_o  (rom_addr),
    .rom_dat_i   (rom_dat),
    .dat_o       (dat_out),
    .diag_o      (diag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [12:0] a, input logic w, input logic [7:0] d);
    adr = a; we = w; dat = d; enable = 1'b1;
    tick();
    enable = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    mapper = 3'd1; superchip = 1'b0; rst = 1'b1; rom_dat = 8'h3C;
    adr = 13'h1000; we = 1'b0; dat = 8'h00; enable = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if (rom_addr !== 15'h1000) begin
      errors++; $display("FAIL reset_f8_addr got %h want %h", rom_addr, 15'h1000);
    end
    checks++;
    if (dat_out !== 8'h3C) begin
      errors++; $display("FAIL reset_dat got %h want %h", dat_out, 8'h3C);
    end
    checks++;
    if (diag !== 16'h2001) begin
      errors++; $display("FAIL reset_diag got %h want %h", diag, 16'h2001);
    end
  endtask

  task automatic test_f8();
    strobe(13'h1FF8, 1'b0, 8'h00);
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h0000) begin
      errors++; $display("FAIL f8_bank0 got %h want %h", rom_addr, 15'h0000);
    end
    strobe(13'h0FF9, 1'b0, 8'h00);
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h0000) begin
      errors++; $display("FAIL f8_a12_low got %h want %h", rom_addr, 15'h0000);
    end
    strobe(13'h1FF9, 1'b0, 8'h00);
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h1000) begin
      errors++; $display("FAIL f8_bank1 got %h want %h", rom_addr, 15'h1000);
    end
    strobe(13'h1FF9, 1'b1, 8'h55);
    adr = 13'h1ABC; #1;
    checks++;
    if (rom_addr !== 15'h1ABC) begin
      errors++; $display("FAIL f8_repeat got %h want %h", rom_addr, 15'h1ABC);
    end
  endtask

  task automatic test_f4();
    mapper = 3'd3; adr = 13'h1234;
    tick();
    checks++;
    if (rom_addr !== 15'h7234) begin
      errors++; $display("FAIL f4_default got %h want %h", rom_addr, 15'h7234);
    end
    adr = 13'h1FF6; enable = 1'b0;
    tick();
    adr = 13'h1234; #1;
    checks++;
    if (rom_addr !== 15'h7234) begin
      errors++; $display("FAIL f4_no_enable got %h want %h", rom_addr, 15'h7234);
    end
    strobe(13'h1FF6, 1'b0, 8'h00);
    adr = 13'h1234; #1;
    checks++;
    if (rom_addr !== 15'h2234) begin
      errors++; $display("FAIL f4_bank2 got %h want %h", rom_addr, 15'h2234);
    end
    strobe(13'h1FF4, 1'b0, 8'h00);
    adr = 13'h1234; #1;
    checks++;
    if (rom_addr !== 15'h0234) begin
      errors++; $display("FAIL f4_bank0 got %h want %h", rom_addr, 15'h0234);
    end
    strobe(13'h1FFB, 1'b0, 8'h00);
    adr = 13'h1234; #1;
    checks++;
    if (rom_addr !== 15'h7234) begin
      errors++; $display("FAIL f4_bank7 got %h want %h", rom_addr, 15'h7234);
    end
  endtask

  task automatic test_e0();
    mapper = 3'd4; adr = 13'h0000;
    tick();
    strobe(13'h1FE5, 1'b0, 8'h00);
    strobe(13'h1FEA, 1'b0, 8'h00);
    strobe(13'h1FF3, 1'b0, 8'h00);
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h1400) begin
      errors++; $display("FAIL e0_slice0 got %h want %h", rom_addr, 15'h1400);
    end
    adr = 13'h1400; #1;
    checks++;
    if (rom_addr !== 15'h0800) begin
      errors++; $display("FAIL e0_slice1 got %h want %h", rom_addr, 15'h0800);
    end
    checks++;
    if (diag !== 16'h8002) begin
      errors++; $display("FAIL e0_diag got %h want %h", diag, 16'h8002);
    end
    adr = 13'h1800; #1;
    checks++;
    if (rom_addr !== 15'h0C00) begin
      errors++; $display("FAIL e0_slice2 got %h want %h", rom_addr, 15'h0C00);
    end
    adr = 13'h1C00; #1;
    checks++;
    if (rom_addr !== 15'h1C00) begin
      errors++; $display("FAIL e0_slice3 got %h want %h", rom_addr, 15'h1C00);
    end
  endtask

  task automatic test_3f();
    mapper = 3'd5; adr = 13'h1100;
    tick();
    checks++;
    if (rom_addr !== 15'h0100) begin
      errors++; $display("FAIL tf_default got %h want %h", rom_addr, 15'h0100);
    end
    strobe(13'h003F, 1'b1, 8'h05);
    adr = 13'h1100; #1;
    checks++;
    if (rom_addr !== 15'h2900) begin
      errors++; $display("FAIL tf_bank5 got %h want %h", rom_addr, 15'h2900);
    end
    adr = 13'h1900; #1;
    checks++;
    if (rom_addr !== 15'h7900) begin
      errors++; $display("FAIL tf_fixed got %h want %h", rom_addr, 15'h7900);
    end
    strobe(13'h0003, 1'b0, 8'h0A);
    strobe(13'h0040, 1'b1, 8'h0A);
    adr = 13'h1100; #1;
    checks++;
    if (rom_addr !== 15'h2900) begin
      errors++; $display("FAIL tf_no_change got %h want %h", rom_addr, 15'h2900);
    end
  endtask

  task automatic test_superchip();
    mapper = 3'd1; superchip = 1'b1; adr = 13'h1200;
    tick();
    strobe(13'h1010, 1'b1, 8'hA5);
    adr = 13'h1090; rom_dat = 8'h5A; #1;
    checks++;
    if (dat_out !== 8'h5A) begin
      errors++; $display("FAIL sc_latency got %h want %h", dat_out, 8'h5A);
    end
    tick();
    checks++;
    if (dat_out !== 8'hA5) begin
      errors++; $display("FAIL sc_read got %h want %h", dat_out, 8'hA5);
    end
    adr = 13'h1200; rom_dat = 8'h77;
    tick();
    checks++;
    if (dat_out !== 8'h77) begin
      errors++; $display("FAIL sc_rom_read got %h want %h", dat_out, 8'h77);
    end
    strobe(13'h107F, 1'b1, 8'h3C);
    adr = 13'h107F; we = 1'b1; dat = 8'hFF; enable = 1'b0;
    tick();
    we = 1'b0; adr = 13'h10FF;
    tick();
    checks++;
    if (dat_out !== 8'h3C) begin
      errors++; $display("FAIL sc_edge_read got %h want %h", dat_out, 8'h3C);
    end
    superchip = 1'b0; adr = 13'h1090;
    tick();
    checks++;
    if (dat_out !== 8'h77) begin
      errors++; $display("FAIL sc_disabled got %h want %h", dat_out, 8'h77);
    end
  endtask

  task automatic test_mapper_change();
    mapper = 3'd2; adr = 13'h1000;
    tick();
    strobe(13'h1FF6, 1'b0, 8'h00);
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h0000) begin
      errors++; $display("FAIL f6_bank0 got %h want %h", rom_addr, 15'h0000);
    end
    mapper = 3'd1;
    tick();
    checks++;
    if (rom_addr !== 15'h1000) begin
      errors++; $display("FAIL change_f8_default got %h want %h", rom_addr, 15'h1000);
    end
    mapper = 3'd2;
    strobe(13'h1FF6, 1'b0, 8'h00);
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h3000) begin
      errors++; $display("FAIL change_beats_hotspot got %h want %h", rom_addr, 15'h3000);
    end
  endtask

  task automatic test_reset_hotspot();
    strobe(13'h1FF7, 1'b0, 8'h00);
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h1000) begin
      errors++; $display("FAIL f6_bank1 got %h want %h", rom_addr, 15'h1000);
    end
    rst = 1'b1;
    strobe(13'h1FF6, 1'b0, 8'h00);
    rst = 1'b0;
    adr = 13'h1000; #1;
    checks++;
    if (rom_addr !== 15'h3000) begin
      errors++; $display("FAIL reset_beats_hotspot got %h want %h", rom_addr, 15'h3000);
    end
  endtask

  initial begin
    test_reset();
    test_f8();
    test_f4();
    test_e0();
    test_3f();
    test_superchip();
    test_mapper_change();
    test_reset_hotspot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
